bank_cmd_scheduler: RTL and testbench

// - Per-bank DRAM command sequencer between the memory request queue and the per-bank command bus.
// - Turns read/write requests into ACT / RD / WR / PRE sequences under an open-page policy.
// - Inserts REFRESH on request and enforces tRCD, tRP, tRAS and tRFC.
// - Its cmd_* outputs feed the per-bank request statistics logger directly.

---
 rtl/bank_cmd_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_bank_cmd_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_scheduler.sv
// Per-bank DRAM command sequencer: turns read/write requests into ACT/RD/WR/PRE
// sequences under an open-page policy and inserts REFRESH on demand, enforcing
// tRCD, tRP, tRAS and tRFC with saturating down-counters.
// Optional build macro: BANK_SCHED_STATS_EN adds hit/miss/refresh counters.
module bank_cmd_scheduler #(
  parameter int unsigned RANK      = 0,
  parameter int unsigned BANKGROUP = 0,
  parameter int unsigned BANK      = 0,
  parameter int unsigned ROW_LSB   = 10,
  parameter int unsigned T_RCD     = 14,
  parameter int unsigned T_RP      = 14,
  parameter int unsigned T_RAS     = 33,
  parameter int unsigned T_RFC     = 260,
  parameter int unsigned CNT_W     = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_is_write,
  input  logic [31:0] req_id,
  input  logic        ref_req,
  output logic        ref_ack,
  output logic        cmd_valid,
  output logic        cmd_cs,
  output logic        cmd_ras,
  output logic        cmd_cas,
  output logic        cmd_we,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic [31:0] cmd_id,
  output logic        row_open,
  output logic        busy
`ifdef BANK_SCHED_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_refs
`endif
);

  localparam int unsigned RowW = 32 - ROW_LSB;

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StActivating  = 3'd1;
  localparam logic [2:0] StOpen        = 3'd2;
  localparam logic [2:0] StPrecharging = 3'd3;
  localparam logic [2:0] StRefresh     = 3'd4;

  // {cs, ras, cas, we}
  localparam logic [3:0] CmdNop = 4'b1111;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;

  localparam logic [CNT_W-1:0] RcdLd = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RpLd  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RasLd = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] RfcLd = CNT_W'(T_RFC - 1);

  // Elaboration-time sanity: every timing must be nonzero and its reload fit the timer
  if (T_RCD < 1 || T_RP < 1 || T_RAS < 1 || T_RFC < 1 || ROW_LSB > 31 ||
      T_RCD > (32'd1 << CNT_W) || T_RP > (32'd1 << CNT_W) ||
      T_RAS > (32'd1 << CNT_W) || T_RFC > (32'd1 << CNT_W)) begin : g_param_err
    $error("bank_cmd_scheduler r%0d/bg%0d/b%0d: bad timing parameters", RANK, BANKGROUP, BANK);
  end

  logic [2:0]       state_q, state_d;
  logic [RowW-1:0]  open_row_q, open_row_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] ras_q, ras_d;
  logic [3:0]       cmd_code;
  logic [3:0]       rdwr_code;
  logic [31:0]      rdwr_data;
  logic [RowW-1:0]  req_row;
  logic             row_hit;

  assign req_row   = req_addr[31:ROW_LSB];
  assign row_hit   = (req_row == open_row_q);
  assign rdwr_code = req_is_write ? CmdWr : CmdRd;
  assign rdwr_data = req_is_write ? req_data : 32'd0;

  assign {cmd_cs, cmd_ras, cmd_cas, cmd_we} = cmd_code;
  assign row_open = (state_q == StOpen);
  assign busy     = (state_q != StIdle);

  // Next-state, timer and command decode; outputs forced to NOP while reset is asserted
  always_comb begin
    state_d    = state_q;
    open_row_d = open_row_q;
    wait_d     = (wait_q == '0) ? '0 : wait_q - CNT_W'(1);
    ras_d      = (ras_q == '0) ? '0 : ras_q - CNT_W'(1);
    cmd_code   = CmdNop;
    cmd_valid  = 1'b0;
    cmd_addr   = 32'd0;
    cmd_data   = 32'd0;
    cmd_id     = 32'd0;
    req_ready  = 1'b0;
    ref_ack    = 1'b0;
    if (!reset) begin
      case (state_q)
        StIdle: begin
          if (ref_req) begin
            cmd_code  = CmdRef;
            cmd_valid = 1'b1;
            ref_ack   = 1'b1;
            wait_d    = RfcLd;
            state_d   = StRefresh;
          end else if (req_valid) begin
            cmd_code   = CmdAct;
            cmd_valid  = 1'b1;
            cmd_addr   = req_addr;
            cmd_id     = req_id;
            open_row_d = req_row;
            wait_d     = RcdLd;
            ras_d      = RasLd;
            state_d    = StActivating;
          end
        end
        StActivating: begin
          if (wait_q == '0) begin
            state_d = StOpen;
            // A withdrawn request leaves the row open with nothing issued
            if (req_valid) begin
              cmd_code  = rdwr_code;
              cmd_valid = 1'b1;
              cmd_addr  = req_addr;
              cmd_data  = rdwr_data;
              cmd_id    = req_id;
              req_ready = 1'b1;
            end
          end
        end
        StOpen: begin
          if (ref_req && ras_q == '0) begin
            cmd_code   = CmdPre;
            cmd_valid  = 1'b1;
            wait_d     = RpLd;
            open_row_d = '0;
            state_d    = StPrecharging;
          end else if (req_valid && row_hit) begin
            cmd_code  = rdwr_code;
            cmd_valid = 1'b1;
            cmd_addr  = req_addr;
            cmd_data  = rdwr_data;
            cmd_id    = req_id;
            req_ready = 1'b1;
          end else if (req_valid && ras_q == '0) begin
            cmd_code   = CmdPre;
            cmd_valid  = 1'b1;
            cmd_addr   = req_addr;
            cmd_id     = req_id;
            wait_d     = RpLd;
            open_row_d = '0;
            state_d    = StPrecharging;
          end
        end
        StPrecharging, StRefresh: begin
          if (wait_q == '0) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, open row and timing counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      open_row_q <= '0;
      wait_q     <= '0;
      ras_q      <= '0;
    end else begin
      state_q    <= state_d;
      open_row_q <= open_row_d;
      wait_q     <= wait_d;
      ras_q      <= ras_d;
    end
  end

`ifdef BANK_SCHED_STATS_EN
  logic [31:0] hits_q, misses_q, refs_q;

  // Event counters; a grant while OPEN is always a row hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q   <= 32'd0;
      misses_q <= 32'd0;
      refs_q   <= 32'd0;
    end else begin
      if (state_q == StOpen && req_ready) hits_q <= hits_q + 32'd1;
      if (cmd_valid && cmd_code == CmdAct) misses_q <= misses_q + 32'd1;
      if (ref_ack) refs_q <= refs_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_refs   = refs_q;
`endif

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Self-checking bench for bank_cmd_scheduler. A transaction-level model predicts
// the absolute cycle of every command from the timing rules; directed steps are
// followed by a randomized request/refresh mix.
module tb_bank_cmd_scheduler;
  localparam int T_RCD = 14;
  localparam int T_RP  = 14;
  localparam int T_RAS = 33;
  localparam int T_RFC = 260;
  localparam logic [3:0] C_NOP = 4'b1111;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_write, ref_req, ref_ack;
  logic [31:0] req_addr, req_data, req_id;
  logic        cmd_valid, cmd_cs, cmd_ras, cmd_cas, cmd_we, row_open, busy;
  logic [31:0] cmd_addr, cmd_data, cmd_id;
`ifdef BANK_SCHED_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_refs;
`endif

  bank_cmd_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_is_write(req_is_write), .req_id(req_id),
    .ref_req(ref_req), .ref_ack(ref_ack),
    .cmd_valid(cmd_valid), .cmd_cs(cmd_cs), .cmd_ras(cmd_ras), .cmd_cas(cmd_cas),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_id(cmd_id),
    .row_open(row_open), .busy(busy)
`ifdef BANK_SCHED_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_refs(stat_refs)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model: row state plus the cycle of the last ACT/PRE/REF
  bit          m_open;
  logic [21:0] m_row;
  int          t_act, t_pre, t_ref;
  int          m_hits, m_miss, m_refs;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_open = 1'b0; m_row = '0;
    t_act = -1000; t_pre = -1000; t_ref = -1000;
    m_hits = 0; m_miss = 0; m_refs = 0;
  endtask

  // Wait (bounded) for the next command and compare it with the prediction
  task automatic wait_cmd(input string tag, input logic [3:0] code, input int exp_cyc,
                          input bit chk_addr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] id, input logic rdy, input logic ack);
    int guard = 0;
    while (cmd_valid !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    check({tag, " valid"}, {31'd0, cmd_valid}, 32'd1);
    check({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " code"}, {28'd0, cmd_cs, cmd_ras, cmd_cas, cmd_we}, {28'd0, code});
    if (chk_addr) check({tag, " addr"}, cmd_addr, a);
    check({tag, " data"}, cmd_data, d);
    check({tag, " id"}, cmd_id, id);
    check({tag, " ready"}, {31'd0, req_ready}, {31'd0, rdy});
    check({tag, " ack"}, {31'd0, ref_ack}, {31'd0, ack});
  endtask

  // ref_req already high at this sample point
  task automatic refresh_seq();
    int now, p, r;
    now = cyc;
    if (m_open) begin
      p = max2(now, t_act + T_RAS);
      wait_cmd("ref_pre", C_PRE, p, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      t_pre = p; m_open = 1'b0;
      tick();
    end
    r = max2(now, max2(t_pre + T_RP + 1, t_ref + T_RFC + 1));
    wait_cmd("ref", C_REF, r, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    t_ref = r; m_refs++;
    @(negedge clk); ref_req = 1'b0; #1;
    check("refresh busy", {31'd0, busy}, 32'd1);
  endtask

  // Request already presented at this sample point
  task automatic serve_req(input logic [31:0] a, input logic wr, input logic [31:0] d,
                           input logic [31:0] id);
    int now, p, x;
    logic [21:0] row;
    logic [3:0]  rw;
    logic [31:0] wd;
    now = cyc; row = a[31:10];
    rw = wr ? C_WR : C_RD;
    wd = wr ? d : 32'd0;
    if (m_open && row == m_row) begin
      wait_cmd("hit", rw, now, 1'b1, a, wd, id, 1'b1, 1'b0);
      m_hits++;
    end else begin
      if (m_open) begin
        p = max2(now, t_act + T_RAS);
        wait_cmd("miss_pre", C_PRE, p, 1'b1, a, 32'd0, id, 1'b0, 1'b0);
        t_pre = p; m_open = 1'b0;
        tick();
      end
      x = max2(now, max2(t_pre + T_RP + 1, t_ref + T_RFC + 1));
      wait_cmd("act", C_ACT, x, 1'b1, a, 32'd0, id, 1'b0, 1'b0);
      t_act = x; m_miss++; m_open = 1'b1; m_row = row;
      tick();
      check("activating row_open", {31'd0, row_open}, 32'd0);
      wait_cmd("first_rdwr", rw, x + T_RCD, 1'b1, a, wd, id, 1'b1, 1'b0);
    end
    @(negedge clk); req_valid = 1'b0; #1;
    check("row_open", {31'd0, row_open}, 32'd1);
  endtask

  task automatic do_req(input logic [31:0] a, input logic wr, input logic [31:0] d,
                        input logic [31:0] id);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_is_write = wr; req_data = d; req_id = id;
    #1;
    serve_req(a, wr, d, id);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; ref_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("reset cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset code", {28'd0, cmd_cs, cmd_ras, cmd_cas, cmd_we}, {28'd0, C_NOP});
    check("reset req_ready", {31'd0, req_ready}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;
    model_reset();
    #1;
  endtask

`ifdef BANK_SCHED_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, " hits"}, stat_hits, 32'(m_hits));
    check({tag, " misses"}, stat_misses, 32'(m_miss));
    check({tag, " refs"}, stat_refs, 32'(m_refs));
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 1'b0; ref_req = 1'b0; req_is_write = 1'b0;
    req_addr = '0; req_data = '0; req_id = '0;
    model_reset();

    do_reset();

    // Asynchronous reset in the middle of a cycle abandons an activation
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_1400; req_is_write = 1'b0; req_id = 32'd7;
    #1;
    check("mid act code", {28'd0, cmd_cs, cmd_ras, cmd_cas, cmd_we}, {28'd0, C_ACT});
    repeat (3) tick();
    check("mid busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async busy", {31'd0, busy}, 32'd0);
    check("async cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("async code", {28'd0, cmd_cs, cmd_ras, cmd_cas, cmd_we}, {28'd0, C_NOP});
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    model_reset();
    #1;

    // Read, same-row write, then a row miss
    do_req(32'h0000_1400, 1'b0, 32'h0, 32'h11);
    do_req(32'h0000_1404, 1'b1, 32'hDEAD_BEEF, 32'h12);
    do_req(32'h0000_2000, 1'b0, 32'h0, 32'h13);

    // Refresh with a row open well past tRAS
    repeat (40) tick();
    @(negedge clk); ref_req = 1'b1; #1;
    refresh_seq();
    repeat (3) tick();
    check("refresh quiet", {31'd0, cmd_valid}, 32'd0);

    // Request and refresh together in IDLE: refresh wins
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; ref_req = 1'b1; req_addr = 32'h0000_0C08; req_is_write = 1'b1;
    req_data = 32'h1234_5678; req_id = 32'h55;
    #1;
    refresh_seq();
    serve_req(32'h0000_0C08, 1'b1, 32'h1234_5678, 32'h55);
`ifdef BANK_SCHED_STATS_EN
    check_stats("both");
`endif

    // Randomized mix of requests over a few rows and occasional refreshes
    for (int k = 0; k < 40; k++) begin
      int gap;
      logic [31:0] a, d, id;
      logic wr;
      gap = $urandom_range(0, 40);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap quiet", {31'd0, cmd_valid}, 32'd0);
      end
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); ref_req = 1'b1; #1;
        refresh_seq();
      end else begin
        a  = (32'($urandom_range(1, 3)) << 10) | ($urandom & 32'h0000_03FC);
        wr = 1'($urandom_range(0, 1));
        d  = $urandom;
        id = $urandom;
        do_req(a, wr, d, id);
      end
    end
`ifdef BANK_SCHED_STATS_EN
    check_stats("final");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
